// File: rtl/disc_reader.sv
// Read-side acquisition engine: timestamps synchronised rddata/index edges and
// emits byte-wide timing codes to acquisition RAM through a small queue.
module disc_reader #(
  parameter int SYNC_STAGES = 2,
  parameter int QDEPTH      = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clken,
  input  logic       rddata,
  input  logic       index,
  input  logic       start,
  input  logic       stop,
  input  logic       wait_idx,
  input  logic       mem_full,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  output logic       running,
  output logic       overrun
);

  localparam int AW = $clog2(QDEPTH);

  typedef enum logic [1:0] {IDLE, ARM, ACQ, DRAIN} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] data_sync, idx_sync;
  logic                   data_hist, idx_hist;
  logic                   data_edge, idx_edge;
  logic                   data_p, idx_p;
  logic [6:0]             timer, timer_n;
  logic [7:0]             c;
  logic                   carry, consume;
  logic [3:0][7:0]        codes;
  logic [1:0]             n_enq;

  logic [7:0]             q [QDEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            count, free, n_ext, n_wr;
  logic                   overflow, deq;

  assign data_edge = data_sync[SYNC_STAGES-1] & ~data_hist;
  assign idx_edge  = idx_sync[SYNC_STAGES-1] & ~idx_hist;

  assign c        = {1'b0, timer} + 8'd1;
  assign carry    = (c == 8'd127);
  assign consume  = (state == ACQ) && !stop && clken;

  // Codes are packed in emission order: carry, then data, then index.
  always_comb begin
    codes   = '0;
    n_enq   = '0;
    timer_n = timer;
    if (consume) begin
      if (data_p || idx_p) begin
        timer_n = '0;
        if (carry) begin
          codes[n_enq] = 8'h7F;
          n_enq        = n_enq + 2'd1;
        end
        if (data_p) begin
          codes[n_enq] = carry ? 8'h00 : c;
          n_enq        = n_enq + 2'd1;
        end
        if (idx_p) begin
          codes[n_enq] = (carry || data_p) ? 8'h80 : (8'h80 | c);
          n_enq        = n_enq + 2'd1;
        end
      end else if (carry) begin
        codes[0] = 8'h7F;
        n_enq    = 2'd1;
        timer_n  = '0;
      end else begin
        timer_n = c[6:0];
      end
    end
  end

  assign free     = (AW+1)'(QDEPTH) - count;
  assign n_ext    = (AW+1)'(n_enq);
  assign overflow = (n_ext > free);
  assign n_wr     = overflow ? free : n_ext;
  assign deq      = !mem_full && (count != '0);

  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < 3; i++) begin
      if (i < 32'(n_wr)) q[wr_ptr + AW'(i)] <= codes[i[1:0]];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      data_sync <= '0;
      idx_sync  <= '0;
      data_hist <= 1'b0;
      idx_hist  <= 1'b0;
      data_p    <= 1'b0;
      idx_p     <= 1'b0;
      timer     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      running   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      data_sync <= {data_sync[SYNC_STAGES-2:0], rddata};
      idx_sync  <= {idx_sync[SYNC_STAGES-2:0], index};
      data_hist <= data_sync[SYNC_STAGES-1];
      idx_hist  <= idx_sync[SYNC_STAGES-1];

      mem_we <= deq;
      if (deq) begin
        mem_wdata <= q[rd_ptr];
        rd_ptr    <= rd_ptr + AW'(1);
      end
      wr_ptr <= wr_ptr + n_wr[AW-1:0];
      count  <= count - (AW+1)'(deq) + n_wr;
      timer  <= timer_n;

      case (state)
        IDLE: begin
          data_p <= 1'b0;
          idx_p  <= 1'b0;
          if (start && !stop) begin
            overrun <= 1'b0;
            running <= 1'b1;
            timer   <= '0;
            state   <= wait_idx ? ARM : ACQ;
          end
        end
        ARM: begin
          data_p <= 1'b0;
          idx_p  <= 1'b0;
          if (stop) begin
            running <= 1'b0;
            state   <= IDLE;
          end else if (idx_edge) begin
            timer <= '0;
            state <= ACQ;
          end
        end
        ACQ: begin
          if (stop || overflow) begin
            data_p <= 1'b0;
            idx_p  <= 1'b0;
            state  <= DRAIN;
            if (overflow) overrun <= 1'b1;
          end else begin
            // A fresh edge landing on the consuming cycle stays pending.
            data_p <= (data_p & ~consume) | data_edge;
            idx_p  <= (idx_p & ~consume) | idx_edge;
          end
        end
        DRAIN: begin
          data_p <= 1'b0;
          idx_p  <= 1'b0;
          if (count == '0) begin
            running <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
